// File: rtl/conv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_arb_pkg
// Description : Shared types and constants for the convolution job arbiter:
//               job FSM state type, default parameters, port-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_arb_pkg;

  localparam int DEF_NUM_CORES   = 4;
  localparam int DEF_DATA_W      = 512;
  localparam int DEF_ADDR_W      = 64;
  localparam int DEF_TIMEOUT_CYC = 65535;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } job_state_e;

  // Width of an index able to address num_ports bus masters (at least 1 bit).
  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : conv_rr_arbiter
// Description : Combinational round-robin picker. Returns a one-hot grant for
//               the first asserted request found scanning upward from ptr_i,
//               wrapping at N.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_rr_arbiter
  import conv_arb_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = port_idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  int               pos;
  logic [IDX_W-1:0] sel;
  logic             found;

  // Scan from the pointer, wrapping once, and keep the first requester.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= N) pos = pos - N;
      sel = IDX_W'(pos);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : conv_job_arbiter
// Description : Job sequencer for NUM_CORES convolution cores plus a
//               round-robin Avalon-MM arbiter between the shared read master
//               (port 0) and the per-core write masters (ports 1..NUM_CORES).
//               Optional watchdog enabled by defining CONV_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_job_arbiter
  import conv_arb_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 Req_i,
  output logic                                 Ack_o,
  input  logic [NUM_CORES-1:0]                 CoreEnable_i,
  output logic [NUM_CORES-1:0]                 CoreStart_o,
  input  logic [NUM_CORES-1:0]                 CoreDone_i,
  output logic                                 Error_o,
  input  logic [(NUM_CORES+1)*ADDR_W-1:0]      MAddr_i,
  input  logic [NUM_CORES:0]                   MRead_i,
  input  logic [NUM_CORES:0]                   MWrite_i,
  input  logic [(NUM_CORES+1)*(DATA_W/8)-1:0]  MByteEnable_i,
  input  logic [(NUM_CORES+1)*DATA_W-1:0]      MWriteData_i,
  input  logic [NUM_CORES:0]                   MLock_i,
  output logic [NUM_CORES:0]                   MWaitReq_o,
  output logic [(NUM_CORES+1)*DATA_W-1:0]      MReadData_o,
  output logic [ADDR_W-1:0]                    AvalonAddr_o,
  output logic                                 AvalonRead_o,
  output logic                                 AvalonWrite_o,
  output logic [DATA_W/8-1:0]                  AvalonByteEnable_o,
  output logic [DATA_W-1:0]                    AvalonWriteData_o,
  output logic                                 AvalonLock_o,
  input  logic [DATA_W-1:0]                    AvalonReadData_i,
  input  logic                                 AvalonWaitReq_i
);

  localparam int NP    = NUM_CORES + 1;
  localparam int IDX_W = port_idx_w(NP);
  localparam int BE_W  = DATA_W / 8;

  if (NUM_CORES < 1 || NUM_CORES > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("conv_job_arbiter: NUM_CORES must be 1..8 and TIMEOUT_CYC >= 1");
  end

  // ---------------------------------------------------------------- job FSM
  job_state_e           state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [NUM_CORES-1:0] w_done_acc;

  // Done pulses of the current cycle count immediately, masked to the job.
  assign w_done_acc = done_q | (CoreDone_i & mask_q);

`ifdef CONV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign Error_o = err_q;
`else
  assign Error_o = 1'b0;
`endif

  assign Ack_o       = (state_q == FINISH);
  assign CoreStart_o = start_q;

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    done_d  = done_q;
    start_d = '0;
`ifdef CONV_ARB_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req_i) begin
`ifdef CONV_ARB_TIMEOUT_EN
          err_d = 1'b0;
          cnt_d = '0;
`endif
          done_d = '0;
          if (|CoreEnable_i) begin
            mask_d  = CoreEnable_i;
            start_d = CoreEnable_i;
            state_d = RUN;
          end else begin
            mask_d  = '0;
            state_d = FINISH;
          end
        end
      end
      RUN: begin
        done_d = w_done_acc;
        if (w_done_acc == mask_q) begin
          state_d = FINISH;
        end
`ifdef CONV_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      done_q  <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

`ifdef CONV_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  // ---------------------------------------------------------------- arbiter
  logic [ADDR_W-1:0] addr_a [NP];
  logic [BE_W-1:0]   be_a   [NP];
  logic [DATA_W-1:0] wd_a   [NP];
  logic [NP-1:0]     w_req;
  logic [NP-1:0]     w_rr_gnt;
  logic [IDX_W-1:0]  w_rr_idx;
  logic              gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  assign w_req       = MRead_i | MWrite_i;
  assign MReadData_o = {NP{AvalonReadData_i}};

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign addr_a[p]     = MAddr_i[p*ADDR_W +: ADDR_W];
    assign be_a[p]       = MByteEnable_i[p*BE_W +: BE_W];
    assign wd_a[p]       = MWriteData_i[p*DATA_W +: DATA_W];
    assign MWaitReq_o[p] = (gnt_vld_q && (gnt_idx_q == IDX_W'(p))) ? AvalonWaitReq_i : 1'b1;
  end

  conv_rr_arbiter #(
    .N     (NP),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (w_req),
    .ptr_i (ptr_q),
    .gnt_o (w_rr_gnt)
  );

  // One-hot grant from the picker converted to a port index.
  always_comb begin
    w_rr_idx = '0;
    for (int p = 0; p < NP; p++) begin
      if (w_rr_gnt[p]) w_rr_idx = IDX_W'(p);
    end
  end

  // Grant hold/release and pointer update.
  always_comb begin
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    if (!gnt_vld_q) begin
      if (|w_req) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = w_rr_idx;
      end
    end else if (!w_req[gnt_idx_q]) begin
      // Master withdrew before completing: drop without touching the pointer.
      gnt_vld_d = 1'b0;
    end else if (!AvalonWaitReq_i) begin
      ptr_d = (gnt_idx_q == IDX_W'(NP - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
      if (!MLock_i[gnt_idx_q]) gnt_vld_d = 1'b0;
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  // Route the granted master onto the Avalon bus; idle bus when no grant.
  always_comb begin
    AvalonAddr_o       = '0;
    AvalonRead_o       = 1'b0;
    AvalonWrite_o      = 1'b0;
    AvalonByteEnable_o = '0;
    AvalonWriteData_o  = '0;
    AvalonLock_o       = 1'b0;
    if (gnt_vld_q) begin
      AvalonAddr_o       = addr_a[gnt_idx_q];
      AvalonRead_o       = MRead_i[gnt_idx_q];
      AvalonWrite_o      = MWrite_i[gnt_idx_q];
      AvalonByteEnable_o = be_a[gnt_idx_q];
      AvalonWriteData_o  = wd_a[gnt_idx_q];
      AvalonLock_o       = MLock_i[gnt_idx_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_job_arbiter
// Description : Directed self-checking bench for conv_job_arbiter
//               (NUM_CORES=4, DATA_W=32, ADDR_W=16, TIMEOUT_CYC=16).
//               Watchdog checks follow CONV_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_job_arbiter;

  localparam int NC = 4;
  localparam int NP = NC + 1;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             Req;
  logic             Ack;
  logic [NC-1:0]    CoreEnable, CoreStart, CoreDone;
  logic             Error;
  logic [NP*AW-1:0] MAddr;
  logic [NP-1:0]    MRead, MWrite, MLock, MWaitReq;
  logic [NP*BW-1:0] MBe;
  logic [NP*DW-1:0] MWd, MReadData;
  logic [AW-1:0]    AvAddr;
  logic             AvRead, AvWrite, AvLock, AvWait;
  logic [BW-1:0]    AvBe;
  logic [DW-1:0]    AvWd, AvRd;

  int n_checks = 0;
  int n_fail   = 0;

  conv_job_arbiter #(
    .NUM_CORES   (NC),
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .Req_i              (Req),
    .Ack_o              (Ack),
    .CoreEnable_i       (CoreEnable),
    .CoreStart_o        (CoreStart),
    .CoreDone_i         (CoreDone),
    .Error_o            (Error),
    .MAddr_i            (MAddr),
    .MRead_i            (MRead),
    .MWrite_i           (MWrite),
    .MByteEnable_i      (MBe),
    .MWriteData_i       (MWd),
    .MLock_i            (MLock),
    .MWaitReq_o         (MWaitReq),
    .MReadData_o        (MReadData),
    .AvalonAddr_o       (AvAddr),
    .AvalonRead_o       (AvRead),
    .AvalonWrite_o      (AvWrite),
    .AvalonByteEnable_o (AvBe),
    .AvalonWriteData_o  (AvWd),
    .AvalonLock_o       (AvLock),
    .AvalonReadData_i   (AvRd),
    .AvalonWaitReq_i    (AvWait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr, input logic lk,
                          input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    MRead[p]           = rd;
    MWrite[p]          = wr;
    MLock[p]           = lk;
    MAddr[p*AW +: AW]  = a;
    MBe[p*BW +: BW]    = be;
    MWd[p*DW +: DW]    = d;
  endtask

  initial begin
    int acks;
    rst = 1'b1; Req = 1'b0; CoreEnable = '0; CoreDone = '0;
    MAddr = '0; MRead = '0; MWrite = '0; MLock = '0; MBe = '0; MWd = '0;
    AvWait = 1'b0; AvRd = '0;

    // ---------------- reset state
    #12;
    check("rst_ack",    Ack, 0);
    check("rst_start",  CoreStart, 0);
    check("rst_error",  Error, 0);
    check("rst_avwr",   AvWrite, 0);
    check("rst_avrd",   AvRead, 0);
    check("rst_avlock", AvLock, 0);
    check("rst_wait",   MWaitReq, 5'b11111);
    @(posedge clk); #1 rst = 1'b0;

    // ---------------- job with mask 0101, dones on core 0 then core 2
    Req = 1; CoreEnable = 4'b0101; tick(); Req = 0;
    check("j1_start", CoreStart, 4'b0101);
    check("j1_ack0",  Ack, 0);
    Req = 1; CoreEnable = 4'b1111; tick(); Req = 0;   // ignored in RUN
    check("j1_start_once", CoreStart, 4'b0000);
    CoreDone = 4'b0001; tick(); CoreDone = 0;
    check("j1_ack_after_d0", Ack, 0);
    CoreDone = 4'b0010; tick(); CoreDone = 0;          // outside mask
    check("j1_ack_unmasked", Ack, 0);
    CoreDone = 4'b0100; tick(); CoreDone = 0;
    check("j1_ack", Ack, 1);
    Req = 1; CoreEnable = 4'b0001; tick(); Req = 0;    // ignored in FINISH
    check("j1_ack_one", Ack, 0);
    check("j1_finish_req_ignored", CoreStart, 0);
    tick();
    check("j1_idle", Ack, 0);

    // ---------------- done arriving in the start cycle
    Req = 1; CoreEnable = 4'b0001; tick(); Req = 0;
    check("j2_start", CoreStart, 4'b0001);
    CoreDone = 4'b0001; tick(); CoreDone = 0;
    check("j2_ack", Ack, 1);
    tick();

    // ---------------- empty mask
    Req = 1; CoreEnable = 4'b0000; tick(); Req = 0;
    check("j3_ack",   Ack, 1);
    check("j3_start", CoreStart, 0);
    tick();
    check("j3_ack_end", Ack, 0);

`ifdef CONV_ARB_TIMEOUT_EN
    // ---------------- watchdog: 16 RUN cycles then forced FINISH
    Req = 1; CoreEnable = 4'b1000; tick(); Req = 0;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (Ack) acks++;
    end
    check("to_early_ack", acks, 0);
    tick();
    check("to_ack",   Ack, 1);
    check("to_error", Error, 1);
    tick();
    check("to_sticky", Error, 1);
    Req = 1; CoreEnable = 4'b0000; tick(); Req = 0;
    check("to_clear", Error, 0);
    tick();
`else
    // ---------------- no watchdog: RUN waits for the done
    Req = 1; CoreEnable = 4'b1000; tick(); Req = 0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Ack || Error) acks++;
    end
    check("nt_wait", acks, 0);
    CoreDone = 4'b1000; tick(); CoreDone = 0;
    check("nt_ack",   Ack, 1);
    check("nt_error", Error, 0);
    tick();
`endif

    // ---------------- round robin: ports 0,1,3 write, no wait states
    AvWait = 0;
    set_port(0, 0, 1, 0, 16'h1000, 4'h1, 32'hA000_0000);
    set_port(1, 0, 1, 0, 16'h1001, 4'h3, 32'hA111_1111);
    set_port(3, 0, 1, 0, 16'h1003, 4'hF, 32'hA333_3333);
    #1;
    check("rr_bubble0", AvWrite, 0);
    tick();
    check("rr_g0_wait", MWaitReq, 5'b11110);
    check("rr_g0_addr", AvAddr, 16'h1000);
    check("rr_g0_wr",   AvWrite, 1);
    tick();
    check("rr_b1_wait", MWaitReq, 5'b11111);
    check("rr_b1_wr",   AvWrite, 0);
    set_port(0, 0, 1, 0, 16'h2000, 4'h1, 32'hB000_0000);  // port 0 asks again
    tick();
    check("rr_g1_wait", MWaitReq, 5'b11101);
    check("rr_g1_addr", AvAddr, 16'h1001);
    check("rr_g1_data", AvWd, 32'hA111_1111);
    check("rr_g1_be",   AvBe, 4'h3);
    tick();
    set_port(1, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    check("rr_b2_wait", MWaitReq, 5'b11111);
    tick();
    check("rr_g3_wait", MWaitReq, 5'b10111);
    check("rr_g3_addr", AvAddr, 16'h1003);
    tick();
    set_port(3, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    tick();
    check("rr_wrap_wait", MWaitReq, 5'b11110);
    check("rr_wrap_addr", AvAddr, 16'h2000);
    tick();
    set_port(0, 0, 0, 0, 16'h0, 4'h0, 32'h0);

    // ---------------- locked burst on port 2 while port 1 waits
    set_port(2, 0, 1, 1, 16'h3002, 4'hF, 32'hC222_2222);
    tick();
    set_port(1, 0, 1, 0, 16'h1001, 4'h3, 32'hA111_1111);
    AvWait = 1; #1;
    check("lk_stall_wait", MWaitReq, 5'b11111);
    check("lk_addr",       AvAddr, 16'h3002);
    AvWait = 0; #1;
    check("lk_x1_wait", MWaitReq, 5'b11011);
    check("lk_x1_lock", AvLock, 1);
    tick();
    check("lk_x2_wait", MWaitReq, 5'b11011);
    tick();
    check("lk_x3_wait", MWaitReq, 5'b11011);
    MLock[2] = 0; #1;
    check("lk_x3_unlock", AvLock, 0);
    tick();
    set_port(2, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    check("lk_release", MWaitReq, 5'b11111);
    tick();
    check("lk_p1_wait", MWaitReq, 5'b11101);
    check("lk_p1_addr", AvAddr, 16'h1001);
    tick();
    set_port(1, 0, 0, 0, 16'h0, 4'h0, 32'h0);

    // ---------------- read on port 4 abandoned under wait states
    AvWait = 1; AvRd = 32'hCAFE_F00D;
    set_port(4, 1, 0, 0, 16'h4004, 4'hF, 32'h0);
    tick();
    check("rd_avrd",  AvRead, 1);
    check("rd_avwr",  AvWrite, 0);
    check("rd_addr",  AvAddr, 16'h4004);
    check("rd_data0", MReadData[0 +: DW], 32'hCAFE_F00D);
    check("rd_data4", MReadData[4*DW +: DW], 32'hCAFE_F00D);
    MRead[4] = 0; #1;
    check("rd_drop_avrd", AvRead, 0);
    tick();
    check("rd_drop_wait", MWaitReq, 5'b11111);

    // ---------------- reset during RUN with stalled granted write
    Req = 1; CoreEnable = 4'b0011; tick(); Req = 0;
    set_port(3, 0, 1, 0, 16'h5003, 4'hF, 32'hD333_3333);
    tick();
    check("ar_granted", AvWrite, 1);
    #2 rst = 1'b1; #1;
    check("ar_avwr",  AvWrite, 0);
    check("ar_avlk",  AvLock, 0);
    check("ar_wait",  MWaitReq, 5'b11111);
    check("ar_ack",   Ack, 0);
    check("ar_start", CoreStart, 0);
    set_port(3, 0, 0, 0, 16'h0, 4'h0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    CoreDone = 4'b0011;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Ack) acks++;
    end
    CoreDone = 0;
    check("ar_no_ack", acks, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
